pipe_stage_reg: RTL and testbench
=================================

# pipe_stage_reg

Generic, parametrised pipeline stage register replacing the per-field hold/flush register banks between pipeline stages (EX/MEM and similar). It carries an opaque DW-bit payload with a valid/ready handshake, a synchronous flush that injects a NOP bubble, and an optional 2-entry skid buffer that registers the upstream ready path. It also provides a saturating back-pressure counter for performance analysis.

## Interface
- DW, 64: payload width in bits; the caller concatenates stage fields into the payload.
- NOP_DATA, {DW{1'b0}}: payload value presented while the stage is empty, after reset and after flush.
- SKID, 1: 1 selects a 2-entry skid buffer with registered in_ready_o; 0 selects a 1-entry stage with combinational in_ready_o.
- CNT_W, 16: width of the stall counter.
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- flush_i  in  1  discard all held entries; highest priority.
- in_valid_i  in  1  upstream offers in_data_i.
- in_ready_o  out  1  stage can accept this cycle.
- in_data_i  in  DW  upstream payload.
- out_valid_o  out  1  out_data_o holds a valid entry.
- out_ready_i  in  1  downstream accepts this cycle.
- out_data_o  out  DW  oldest held payload, or NOP_DATA when empty.
- count_o  out  2  entries held (0..2; max 1 when SKID=0).
- stall_cnt_o  out  CNT_W  cycles with out_valid_o=1 and out_ready_i=0, saturating.

## Operation
- in_fire = in_valid_i & in_ready_o; out_fire = out_valid_o & out_ready_i.
- Storage is a main register and, when SKID=1, a skid register. out_data_o is the main register.
- Entries leave in strict arrival order. Payload passes through unmodified.
- States: EMPTY, ONE, TWO. TWO is unreachable when SKID=0.
  - EMPTY:
    - in_fire -> ONE, main <= in_data_i.
  - ONE:
    - in_fire & out_fire -> ONE, main <= in_data_i.
    - in_fire & !out_fire -> TWO, skid <= in_data_i. SKID=1 only.
    - out_fire & !in_fire -> EMPTY, main <= NOP_DATA.
  - TWO:
    - in_ready_o = 0.
    - out_fire -> ONE, main <= skid, skid <= NOP_DATA.
- in_ready_o:
  - SKID=1: registered, equal to (state != TWO).
  - SKID=0: (state == EMPTY) | out_ready_i.
  - Both modes: forced to 0 while flush_i = 1 (combinational gate).
- Flush:
  - Next state is EMPTY; main and skid are loaded with NOP_DATA.
  - Any in_valid_i in the flush cycle is dropped.
  - out_fire in the flush cycle still counts as a downstream transfer of the current out_data_o.
- Stall counter:
  - Increments when out_valid_o & !out_ready_i.
  - Holds at 2^CNT_W-1.
  - Cleared only by rst; flush does not clear it.
- out_valid_o = (state != EMPTY). count_o encodes state: 0, 1, 2.

## Timing
- Reset values:
  - State EMPTY, main = skid = NOP_DATA.
  - out_valid_o = 0, out_data_o = NOP_DATA.
  - in_ready_o = 1 in both modes.
  - count_o = 0, stall_cnt_o = 0.
- rst has priority over flush_i. flush_i has priority over the handshakes.
- Reset mid-operation discards all entries in one cycle.
- Latency: data accepted at edge N appears on out_data_o with out_valid_o=1 after edge N, i.e. 1 cycle.
- Throughput: 1 entry per cycle in both modes when out_ready_i is held at 1.
- SKID=1: upstream may see in_ready_o=1 for one cycle after downstream stalls; the skid absorbs that entry. No combinational path runs from out_ready_i to in_ready_o.
- SKID=0: combinational path out_ready_i -> in_ready_o. Full-rate pass-through is required (ONE with simultaneous in/out fire).
- The upstream must hold in_valid_i and in_data_i stable until in_fire; the stage does not check this.

## Structure
- Shared package pipe_pkg:
  - State encoding enum (EMPTY=2'd0, ONE=2'd1, TWO=2'd2), matching count_o.
  - Constant INST_NOP (32'h00000013) for callers building NOP_DATA.
- One sub-module, sat_counter (parameter W, inputs clk/rst/inc, output cnt), used for stall_cnt_o.
- The FSM and storage stay inline. Use a generate on SKID to omit the skid register when SKID=0.

## Test plan
- Reset, then stream 0x1, 0x2, 0x3 with out_ready_i=1, SKID=1, DW=64.
  - out_data_o = 0x1, 0x2, 0x3 on consecutive cycles, 1 cycle after each accept.
  - in_ready_o stays 1; count_o=1; stall_cnt_o=0.
- SKID=1, hold out_ready_i=0 while offering 0xA, 0xB, 0xC.
  - 0xA and 0xB accepted; in_ready_o drops to 0 after the second accept; count_o=2; 0xC held upstream.
  - Release out_ready_i: outputs 0xA, 0xB, 0xC in order.
  - stall_cnt_o equals the stalled cycle count.
- Flush in state TWO with in_valid_i=1, data 0xD.
  - Next cycle out_valid_o=0, out_data_o=NOP_DATA, count_o=0.
  - 0xD is never emitted; stall_cnt_o is unchanged.
- SKID=0, out_ready_i toggling 1,0,1 with continuous input.
  - in_ready_o follows (state==EMPTY)|out_ready_i combinationally.
  - No loss or duplication; count_o never exceeds 1.
- CNT_W=4, stall 20 cycles.
  - stall_cnt_o saturates at 15.
  - Assert rst mid-stream: all outputs return to reset values next cycle.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared definitions for pipeline stage registers.
package pipe_pkg;

   // Occupancy state; encoding doubles as the entry count.
   typedef enum logic [1:0] {
      StEmpty = 2'd0,
      StOne   = 2'd1,
      StTwo   = 2'd2
   } pipe_state_e;

   // RISC-V addi x0,x0,0; callers use it to build a NOP payload.
   localparam logic [31:0] INST_NOP = 32'h0000_0013;

endpackage : pipe_pkg

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous active-high reset.
module sat_counter #(
   parameter int unsigned W = 16
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         inc,
   output logic [W-1:0] cnt
);

   logic [W-1:0] cnt_q, cnt_d;

   // Increment on request unless already at all-ones.
   always_comb begin
      cnt_d = cnt_q;
      if (inc && (cnt_q != {W{1'b1}})) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   // Counter state register.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt = cnt_q;

endmodule : sat_counter

// File: rtl/pipe_stage_reg.sv
// Generic valid/ready pipeline stage with flush and optional 2-entry skid buffer.
module pipe_stage_reg #(
   parameter int unsigned   DW       = 64,
   parameter logic [DW-1:0] NOP_DATA = '0,
   parameter bit            SKID     = 1'b1,
   parameter int unsigned   CNT_W    = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush_i,
   input  logic             in_valid_i,
   output logic             in_ready_o,
   input  logic [DW-1:0]    in_data_i,
   output logic             out_valid_o,
   input  logic             out_ready_i,
   output logic [DW-1:0]    out_data_o,
   output logic [1:0]       count_o,
   output logic [CNT_W-1:0] stall_cnt_o
);

   import pipe_pkg::*;

   pipe_state_e   state_q, state_d;
   logic [DW-1:0] main_q, main_d;
   logic [DW-1:0] skid_q, skid_d;
   logic          ready_raw;
   logic          in_fire, out_fire;

   assign out_valid_o = (state_q != StEmpty);
   assign out_data_o  = main_q;
   assign count_o     = state_q;
   // Flush gates ready combinationally so nothing is accepted in a flush cycle.
   assign in_ready_o  = ready_raw & ~flush_i;
   assign in_fire     = in_valid_i & in_ready_o;
   assign out_fire    = out_valid_o & out_ready_i;

   // Occupancy FSM and storage next-state; flush beats the handshakes.
   always_comb begin
      state_d = state_q;
      main_d  = main_q;
      skid_d  = skid_q;
      if (flush_i) begin
         state_d = StEmpty;
         main_d  = NOP_DATA;
         skid_d  = NOP_DATA;
      end else begin
         unique case (state_q)
            StEmpty: begin
               if (in_fire) begin
                  state_d = StOne;
                  main_d  = in_data_i;
               end
            end
            StOne: begin
               if (in_fire && out_fire) begin
                  main_d = in_data_i;
               end else if (SKID && in_fire) begin
                  state_d = StTwo;
                  skid_d  = in_data_i;
               end else if (out_fire) begin
                  state_d = StEmpty;
                  main_d  = NOP_DATA;
               end
            end
            StTwo: begin
               if (out_fire) begin
                  state_d = StOne;
                  main_d  = skid_q;
                  skid_d  = NOP_DATA;
               end
            end
            default: begin
               state_d = StEmpty;
               main_d  = NOP_DATA;
               skid_d  = NOP_DATA;
            end
         endcase
      end
   end

   // State and main register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StEmpty;
         main_q  <= NOP_DATA;
      end else begin
         state_q <= state_d;
         main_q  <= main_d;
      end
   end

   if (SKID) begin : g_skid
      logic rdy_q;

      // Skid register plus registered ready, so out_ready_i never reaches in_ready_o.
      always_ff @(posedge clk) begin
         if (rst) begin
            skid_q <= NOP_DATA;
            rdy_q  <= 1'b1;
         end else begin
            skid_q <= skid_d;
            rdy_q  <= (state_d != StTwo);
         end
      end

      assign ready_raw = rdy_q;
   end else begin : g_no_skid
      logic unused_skid_d;

      assign skid_q        = NOP_DATA;
      assign unused_skid_d = ^skid_d;
      // Accept when empty, or when the held entry leaves this same cycle.
      assign ready_raw     = (state_q == StEmpty) | out_ready_i;
   end

   sat_counter #(
      .W(CNT_W)
   ) u_stall_cnt (
      .clk(clk),
      .rst(rst),
      .inc(out_valid_o & ~out_ready_i),
      .cnt(stall_cnt_o)
   );

endmodule : pipe_stage_reg

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench: three stage instances against a FIFO-level model.
module tb_pipe_stage_reg;

   localparam logic [63:0] NOP0 = 64'h0000_0000_0000_0013;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        flush     [3];
   logic        in_valid  [3];
   logic        in_ready  [3];
   logic [63:0] in_data   [3];
   logic        out_valid [3];
   logic        out_ready [3];
   logic [63:0] out_data  [3];
   logic [1:0]  count     [3];
   logic [15:0] stall     [3];
   logic [3:0]  stall2;

   always #5 clk = ~clk;

   // inst 0: SKID=1, non-zero NOP; inst 1: SKID=0; inst 2: SKID=1, CNT_W=4
   pipe_stage_reg #(.DW(64), .NOP_DATA({32'h0, pipe_pkg::INST_NOP}), .SKID(1'b1), .CNT_W(16))
   u_dut0 (.clk(clk), .rst(rst), .flush_i(flush[0]), .in_valid_i(in_valid[0]),
           .in_ready_o(in_ready[0]), .in_data_i(in_data[0]), .out_valid_o(out_valid[0]),
           .out_ready_i(out_ready[0]), .out_data_o(out_data[0]), .count_o(count[0]),
           .stall_cnt_o(stall[0]));

   pipe_stage_reg #(.DW(64), .NOP_DATA(64'h0), .SKID(1'b0), .CNT_W(16))
   u_dut1 (.clk(clk), .rst(rst), .flush_i(flush[1]), .in_valid_i(in_valid[1]),
           .in_ready_o(in_ready[1]), .in_data_i(in_data[1]), .out_valid_o(out_valid[1]),
           .out_ready_i(out_ready[1]), .out_data_o(out_data[1]), .count_o(count[1]),
           .stall_cnt_o(stall[1]));

   pipe_stage_reg #(.DW(64), .NOP_DATA(64'h0), .SKID(1'b1), .CNT_W(4))
   u_dut2 (.clk(clk), .rst(rst), .flush_i(flush[2]), .in_valid_i(in_valid[2]),
           .in_ready_o(in_ready[2]), .in_data_i(in_data[2]), .out_valid_o(out_valid[2]),
           .out_ready_i(out_ready[2]), .out_data_o(out_data[2]), .count_o(count[2]),
           .stall_cnt_o(stall2));

   assign stall[2] = {12'h0, stall2};

   // ---------------- model: a bounded FIFO per instance ----------------
   bit          skid_m [3] = '{1'b1, 1'b0, 1'b1};
   int          smax   [3] = '{65535, 65535, 15};
   logic [63:0] nop_m  [3] = '{NOP0, 64'h0, 64'h0};
   logic [63:0] mq     [3][2];
   int          mcnt   [3] = '{0, 0, 0};
   int          mstall [3] = '{0, 0, 0};
   bit          acc    [3] = '{1'b0, 1'b0, 1'b0};
   logic [63:0] elog   [3][64];
   int          ecnt   [3] = '{0, 0, 0};

   int n_chk  = 0;
   int n_fail = 0;
   bit chk_en = 1'b0;

   function automatic bit exp_ready(int i);
      if (flush[i]) return 1'b0;
      if (skid_m[i]) return (mcnt[i] < 2);
      return (mcnt[i] == 0) || out_ready[i];
   endfunction

   function automatic logic [63:0] exp_data(int i);
      return (mcnt[i] > 0) ? mq[i][0] : nop_m[i];
   endfunction

   task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic model_step();
      for (int i = 0; i < 3; i++) begin
         bit inf, outf;
         if (rst) begin
            mcnt[i]   = 0;
            mstall[i] = 0;
            acc[i]    = 1'b0;
         end else begin
            inf    = in_valid[i] && exp_ready(i);
            outf   = (mcnt[i] > 0) && out_ready[i];
            acc[i] = inf;
            if ((mcnt[i] > 0) && !out_ready[i] && (mstall[i] < smax[i])) mstall[i]++;
            if (outf && (ecnt[i] < 64)) begin
               elog[i][ecnt[i]] = mq[i][0];
               ecnt[i]++;
            end
            if (flush[i]) begin
               mcnt[i] = 0;
            end else begin
               if (outf) begin
                  mq[i][0] = mq[i][1];
                  mcnt[i]--;
               end
               if (inf) begin
                  mq[i][mcnt[i]] = in_data[i];
                  mcnt[i]++;
               end
            end
         end
      end
   endtask

   initial forever begin
      @(posedge clk);
      model_step();
   end

   // Every-cycle comparison against the model.
   initial forever begin
      @(negedge clk);
      if (chk_en) begin
         for (int i = 0; i < 3; i++) begin
            chk($sformatf("i%0d out_valid", i), {63'h0, out_valid[i]}, {63'h0, mcnt[i] > 0});
            chk($sformatf("i%0d out_data", i), out_data[i], exp_data(i));
            chk($sformatf("i%0d in_ready", i), {63'h0, in_ready[i]}, {63'h0, exp_ready(i)});
            chk($sformatf("i%0d count", i), {62'h0, count[i]}, 64'(mcnt[i]));
            chk($sformatf("i%0d stall_cnt", i), {48'h0, stall[i]}, 64'(mstall[i]));
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // ---------------- directed stimulus with literal pins ----------------
   initial begin
      int nacc;
      for (int i = 0; i < 3; i++) begin
         flush[i]     = 1'b0;
         in_valid[i]  = 1'b0;
         in_data[i]   = '0;
         out_ready[i] = 1'b1;
      end
      step();
      chk_en = 1'b1;
      step();
      rst = 1'b0;
      chk("rst out_valid", {63'h0, out_valid[0]}, 64'h0);
      chk("rst out_data nop", out_data[0], NOP0);
      chk("rst in_ready skid", {63'h0, in_ready[0]}, 64'h1);
      chk("rst in_ready noskid", {63'h0, in_ready[1]}, 64'h1);
      chk("rst count", {62'h0, count[0]}, 64'h0);
      chk("rst stall", {48'h0, stall[0]}, 64'h0);

      // Stream 1,2,3 at full rate.
      in_valid[0] = 1'b1;
      in_data[0]  = 64'h1;
      step();
      chk("stream d1", out_data[0], 64'h1);
      chk("stream cnt1", {62'h0, count[0]}, 64'h1);
      in_data[0] = 64'h2;
      step();
      chk("stream d2", out_data[0], 64'h2);
      in_data[0] = 64'h3;
      step();
      chk("stream d3", out_data[0], 64'h3);
      chk("stream ready", {63'h0, in_ready[0]}, 64'h1);
      in_valid[0] = 1'b0;
      step();
      chk("stream drained", {62'h0, count[0]}, 64'h0);

      // Back-pressure into the skid: A, B taken, C held.
      out_ready[0] = 1'b0;
      in_valid[0]  = 1'b1;
      in_data[0]   = 64'hA;
      step();
      chk("bp cnt1", {62'h0, count[0]}, 64'h1);
      in_data[0] = 64'hB;
      step();
      chk("bp cnt2", {62'h0, count[0]}, 64'h2);
      chk("bp ready low", {63'h0, in_ready[0]}, 64'h0);
      chk("bp head A", out_data[0], 64'hA);
      in_data[0] = 64'hC;
      step();
      step();
      chk("bp stall3", {48'h0, stall[0]}, 64'h3);
      out_ready[0] = 1'b1;
      step();
      chk("bp head B", out_data[0], 64'hB);
      chk("bp ready back", {63'h0, in_ready[0]}, 64'h1);
      step();
      chk("bp head C", out_data[0], 64'hC);
      in_valid[0] = 1'b0;
      step();
      chk("bp drained", {62'h0, count[0]}, 64'h0);

      // Fill to TWO, then flush while offering D.
      out_ready[0] = 1'b0;
      in_valid[0]  = 1'b1;
      in_data[0]   = 64'hE;
      step();
      in_data[0] = 64'hF;
      step();
      chk("fl full", {62'h0, count[0]}, 64'h2);
      in_data[0]   = 64'hD;
      flush[0]     = 1'b1;
      out_ready[0] = 1'b1;
      #1;
      chk("fl ready gated", {63'h0, in_ready[0]}, 64'h0);
      step();
      chk("fl out_valid", {63'h0, out_valid[0]}, 64'h0);
      chk("fl out_data", out_data[0], NOP0);
      chk("fl count", {62'h0, count[0]}, 64'h0);
      chk("fl stall kept", {48'h0, stall[0]}, 64'h4);
      flush[0]    = 1'b0;
      in_valid[0] = 1'b0;
      step();
      chk("fl still empty", {63'h0, out_valid[0]}, 64'h0);
      chk("i0 emitted", 64'(ecnt[0]), 64'd7);
      begin
         logic [63:0] exp0 [7] = '{64'h1, 64'h2, 64'h3, 64'hA, 64'hB, 64'hC, 64'hE};
         for (int j = 0; j < 7; j++) chk($sformatf("i0 order %0d", j), elog[0][j], exp0[j]);
      end

      // No-skid stage, out_ready toggling 1,0,1 under continuous input.
      nacc        = 0;
      in_valid[1] = 1'b1;
      in_data[1]  = 64'h10;
      for (int k = 0; k < 12; k++) begin
         out_ready[1] = ((k % 3) != 1);
         step();
         if (acc[1]) nacc++;
         in_data[1] = 64'h10 + 64'(nacc);
      end
      out_ready[1] = 1'b0;
      step();
      in_valid[1] = 1'b0;
      #1;
      chk("ns comb ready low", {63'h0, in_ready[1]}, 64'h0);
      out_ready[1] = 1'b1;
      #1;
      chk("ns comb ready high", {63'h0, in_ready[1]}, 64'h1);
      step();
      chk("ns accepted", 64'(nacc), 64'd8);
      chk("ns emitted", 64'(ecnt[1]), 64'd8);
      chk("ns stall", {48'h0, stall[1]}, 64'd5);
      for (int j = 0; j < 8; j++) chk($sformatf("ns order %0d", j), elog[1][j], 64'h10 + 64'(j));

      // Stall counter saturation, then reset mid-stream.
      out_ready[2] = 1'b0;
      in_valid[2]  = 1'b1;
      in_data[2]   = 64'h55;
      step();
      in_valid[2] = 1'b0;
      repeat (20) step();
      chk("sat stall 15", {48'h0, stall[2]}, 64'd15);
      chk("sat head", out_data[2], 64'h55);
      in_valid[2] = 1'b1;
      in_data[2]  = 64'h66;
      rst         = 1'b1;
      step();
      chk("mrst out_valid", {63'h0, out_valid[2]}, 64'h0);
      chk("mrst count", {62'h0, count[2]}, 64'h0);
      chk("mrst stall", {48'h0, stall[2]}, 64'h0);
      chk("mrst in_ready", {63'h0, in_ready[2]}, 64'h1);
      chk("mrst out_data", out_data[2], 64'h0);
      rst         = 1'b0;
      in_valid[2] = 1'b0;
      step();
      chk("post rst empty", {63'h0, out_valid[2]}, 64'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule : tb_pipe_stage_reg
